traffic_light_monitor: RTL and testbench

- Passive checker on the receiving end of the 3-bit one-hot traffic-light bus driven by the team's light controller.
- Decodes the bus into a phase and checks encoding legality, phase order (RED->GREEN->YELLOW->RED) and per-phase dwell time.
- Reports per-event error pulses, a sticky error flag, the last measured dwell and a completed-cycle count.
- Sits beside the controller in the same clock domain; used in system integration and as an embedded safety monitor.

---
 rtl/traffic_light_pkg.sv | 35 +++
 rtl/traffic_light_monitor_if.sv | 26 ++
 rtl/tl_dwell_timer.sv | 58 +++++
 rtl/traffic_light_monitor.sv | 124 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light bus: phase encoding, light codes
// and the legal phase sequence, used by both the controller and the monitor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED     = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10,
    PH_UNKNOWN = 2'b11
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b100;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_UNKNOWN;
    endcase
  endfunction

  // Anything that is not exactly one lamp maps to UNKNOWN.
  function automatic phase_t decode_light(input logic [2:0] l);
    case (l)
      LIGHT_RED:    return PH_RED;
      LIGHT_GREEN:  return PH_GREEN;
      LIGHT_YELLOW: return PH_YELLOW;
      default:      return PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Traffic-light bus as seen by the monitor: observed light and clear in,
// decoded phase, error flags and statistics out.
interface traffic_light_monitor_if;
  logic [2:0]  light;
  logic        clear;
  logic [1:0]  phase;
  logic        err_onehot;
  logic        err_order;
  logic        err_timing;
  logic        err_sticky;
  logic        cycle_done;
  logic [15:0] cycle_count;
  logic [31:0] last_dwell;

  modport master (
    output light, clear,
    input  phase, err_onehot, err_order, err_timing, err_sticky,
           cycle_done, cycle_count, last_dwell
  );

  modport slave (
    input  light, clear,
    output phase, err_onehot, err_order, err_timing, err_sticky,
           cycle_done, cycle_count, last_dwell
  );
endinterface

// File: rtl/tl_dwell_timer.sv
// Saturating per-phase dwell counter with the expected-range compare for the
// phase currently being measured.
module tl_dwell_timer
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 2500,
  parameter int GREEN_CYCLES  = 2500,
  parameter int YELLOW_CYCLES = 250,
  parameter int TOL           = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        clr_i,
  input  phase_t      phase_i,
  output logic [31:0] dwell_o,
  output logic        overrun_o,
  output logic        short_o
);

  logic [31:0] dwell_q, dwell_d;
  logic [31:0] exp_c, lo_c, hi_c;

  always_comb begin
    case (phase_i)
      PH_RED:    exp_c = 32'(RED_CYCLES);
      PH_GREEN:  exp_c = 32'(GREEN_CYCLES);
      PH_YELLOW: exp_c = 32'(YELLOW_CYCLES);
      default:   exp_c = 32'd0;
    endcase
    lo_c = (32'(TOL) >= exp_c) ? 32'd1 : exp_c - 32'(TOL);
    hi_c = exp_c + 32'(TOL);
  end

  always_comb begin
    dwell_d = dwell_q;
    if (clr_i)
      dwell_d = 32'd0;
    else if (load_i)
      dwell_d = 32'd1;
    else if (hold_i && dwell_q != '1)
      dwell_d = dwell_q + 32'd1;
  end

  // Fires only on the increment that first crosses the upper bound.
  assign overrun_o = hold_i && (dwell_d != dwell_q) && (dwell_d == hi_c + 32'd1);
  assign short_o   = dwell_q < lo_c;
  assign dwell_o   = dwell_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dwell_q <= 32'd0;
    else
      dwell_q <= dwell_d;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot traffic-light bus: tracks the phase, flags
// illegal codes, out-of-order transitions and dwell-time violations.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 2500,
  parameter int GREEN_CYCLES  = 2500,
  parameter int YELLOW_CYCLES = 250,
  parameter int TOL           = 0
) (
  input logic               clk,
  input logic               reset,
  traffic_light_monitor_if.slave bus
);

  phase_t      state_q, state_d;
  logic        timed_q, timed_d;
  logic        bad_q, bad_d;
  logic        err_onehot_q, err_onehot_d;
  logic        err_order_q, err_order_d;
  logic        err_timing_q, err_timing_d;
  logic        err_sticky_q, err_sticky_d;
  logic        cycle_done_q, cycle_done_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic [31:0] last_dwell_q, last_dwell_d;

  phase_t      sample_c;
  logic        legal_c, change_c, load_c, hold_c;
  logic [31:0] dwell_c;
  logic        overrun_c, short_c;

  assign sample_c = decode_light(bus.light);
  assign legal_c  = (sample_c != PH_UNKNOWN);
  assign load_c   = legal_c && (sample_c != state_q);
  assign hold_c   = legal_c && (sample_c == state_q);
  assign change_c = load_c && (state_q != PH_UNKNOWN);

  tl_dwell_timer #(
    .RED_CYCLES   (RED_CYCLES),
    .GREEN_CYCLES (GREEN_CYCLES),
    .YELLOW_CYCLES(YELLOW_CYCLES),
    .TOL          (TOL)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_c),
    .hold_i   (hold_c),
    .clr_i    (!legal_c),
    .phase_i  (state_q),
    .dwell_o  (dwell_c),
    .overrun_o(overrun_c),
    .short_o  (short_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PH_UNKNOWN;
      timed_q       <= 1'b0;
      bad_q         <= 1'b0;
      err_onehot_q  <= 1'b0;
      err_order_q   <= 1'b0;
      err_timing_q  <= 1'b0;
      err_sticky_q  <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= 16'd0;
      last_dwell_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      timed_q       <= timed_d;
      bad_q         <= bad_d;
      err_onehot_q  <= err_onehot_d;
      err_order_q   <= err_order_d;
      err_timing_q  <= err_timing_d;
      err_sticky_q  <= err_sticky_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
      last_dwell_q  <= last_dwell_d;
    end
  end

  // A phase entered from SYNC is only trustworthy if we saw it start, i.e.
  // the sample just before it was an illegal code rather than reset.
  always_comb begin
    state_d = state_q;
    timed_d = timed_q;
    bad_d   = bad_q;
    if (!legal_c) begin
      state_d = PH_UNKNOWN;
      timed_d = 1'b0;
      bad_d   = 1'b1;
    end else if (state_q == PH_UNKNOWN) begin
      state_d = sample_c;
      timed_d = bad_q;
      bad_d   = 1'b0;
    end else if (change_c) begin
      state_d = sample_c;
      timed_d = 1'b1;
    end
  end

  always_comb begin
    err_onehot_d = !legal_c;
    err_order_d  = change_c && (sample_c != next_phase(state_q));
    err_timing_d = timed_q && ((change_c && short_c) || (hold_c && overrun_c));
    cycle_done_d = change_c && (state_q == PH_YELLOW) && (sample_c == PH_RED);
    last_dwell_d = change_c ? dwell_c : last_dwell_q;
    err_sticky_d = (err_sticky_q && !bus.clear) ||
                   err_onehot_d || err_order_d || err_timing_d;
    if (bus.clear)
      cycle_count_d = {15'd0, cycle_done_d};
    else
      cycle_count_d = cycle_count_q + {15'd0, cycle_done_d};
  end

  assign bus.phase       = state_q;
  assign bus.err_onehot  = err_onehot_q;
  assign bus.err_order   = err_order_q;
  assign bus.err_timing  = err_timing_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.cycle_done  = cycle_done_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.last_dwell  = last_dwell_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised bench for traffic_light_monitor: a run-length model of the light
// sequence predicts every output, checked each falling edge.
module tb_traffic_light_monitor;

  localparam int RC   = 10;
  localparam int GC   = 10;
  localparam int YC   = 3;
  localparam int TOLP = 0;

  logic clk = 1'b0;
  logic reset;
  traffic_light_monitor_if bus();

  traffic_light_monitor #(
    .RED_CYCLES   (RC),
    .GREEN_CYCLES (GC),
    .YELLOW_CYCLES(YC),
    .TOL          (TOLP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int exp_len[3] = '{RC, GC, YC};

  // Model: current phase (-1 = unknown), run length of that phase, whether the
  // run is measured from its true start, and whether its overrun was reported.
  int m_p, m_run;
  bit m_timed, m_prev_bad, m_reported;
  logic [1:0]  x_phase;
  logic        x_onehot, x_order, x_timing, x_sticky, x_done;
  logic [15:0] x_count;
  logic [31:0] x_last;

  function automatic logic [2:0] code_of(input int p);
    case (p)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic int lo_of(input int p);
    return (TOLP >= exp_len[p]) ? 1 : exp_len[p] - TOLP;
  endfunction

  function automatic int hi_of(input int p);
    return exp_len[p] + TOLP;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_p = -1; m_run = 0; m_timed = 0; m_prev_bad = 0; m_reported = 0;
    x_phase = 2'b11; x_onehot = 0; x_order = 0; x_timing = 0;
    x_sticky = 0; x_done = 0; x_count = 16'd0; x_last = 32'd0;
  endtask

  task automatic model_step(input logic [2:0] l, input bit c);
    int sp;
    bit legal;
    legal = (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
    sp = (l == 3'b001) ? 0 : (l == 3'b010) ? 1 : 2;
    x_onehot = 0; x_order = 0; x_timing = 0; x_done = 0;
    if (!legal) begin
      x_onehot = 1;
      m_p = -1; m_run = 0; m_timed = 0; m_prev_bad = 1; m_reported = 0;
    end else if (m_p < 0) begin
      m_p = sp; m_run = 1; m_timed = m_prev_bad; m_prev_bad = 0; m_reported = 0;
    end else if (sp != m_p) begin
      x_last = 32'(m_run);
      if (m_timed && (m_run < lo_of(m_p) || (m_run > hi_of(m_p) && !m_reported)))
        x_timing = 1;
      if (sp != (m_p + 1) % 3)
        x_order = 1;
      else if (m_p == 2)
        x_done = 1;
      m_p = sp; m_run = 1; m_timed = 1; m_reported = 0;
    end else begin
      m_run++;
      if (m_timed && m_run > hi_of(m_p) && !m_reported) begin
        x_timing = 1;
        m_reported = 1;
      end
    end
    x_phase  = (m_p < 0) ? 2'b11 : 2'(m_p);
    x_sticky = (x_sticky && !c) || x_onehot || x_order || x_timing;
    if (c) x_count = {15'd0, x_done};
    else   x_count = x_count + {15'd0, x_done};
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("phase",       32'(bus.phase),       32'(x_phase));
      cmp("err_onehot",  32'(bus.err_onehot),  32'(x_onehot));
      cmp("err_order",   32'(bus.err_order),   32'(x_order));
      cmp("err_timing",  32'(bus.err_timing),  32'(x_timing));
      cmp("err_sticky",  32'(bus.err_sticky),  32'(x_sticky));
      cmp("cycle_done",  32'(bus.cycle_done),  32'(x_done));
      cmp("cycle_count", 32'(bus.cycle_count), 32'(x_count));
      cmp("last_dwell",  bus.last_dwell,       x_last);
    end
  end

  task automatic step(input logic [2:0] l, input bit c);
    bus.light = l;
    bus.clear = c;
    @(posedge clk);
    model_step(l, c);
    #1;
  endtask

  task automatic drive(input logic [2:0] l, input int n);
    for (int k = 0; k < n; k++) step(l, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [2:0] bad_tab[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    int r, n, len, rp;
    reset = 1'b1;
    bus.light = 3'b001;
    bus.clear = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp("rst_phase", 32'(bus.phase), 32'd3);
    cmp("rst_count", 32'(bus.cycle_count), 32'd0);
    cmp("rst_last", bus.last_dwell, 32'd0);

    // 1: partial RED then a clean cycle
    drive(3'b001, 7); drive(3'b010, 10); drive(3'b100, 3); step(3'b001, 0);
    cmp("s1_done", 32'(bus.cycle_done), 32'd1);
    cmp("s1_count", 32'(bus.cycle_count), 32'd1);
    cmp("s1_last", bus.last_dwell, 32'd3);
    cmp("s1_sticky", 32'(bus.err_sticky), 32'd0);
    $display("scenario 1: clean cycle, count=%0d", bus.cycle_count);

    // 2: YELLOW held one cycle too long
    drive(3'b001, 9); drive(3'b010, 10); drive(3'b100, 3); step(3'b100, 0);
    cmp("s2_overrun", 32'(bus.err_timing), 32'd1);
    step(3'b001, 0);
    cmp("s2_exit_timing", 32'(bus.err_timing), 32'd0);
    cmp("s2_done", 32'(bus.cycle_done), 32'd1);
    cmp("s2_last", bus.last_dwell, 32'd4);
    cmp("s2_sticky", 32'(bus.err_sticky), 32'd1);
    $display("scenario 2: yellow overrun, sticky=%0d", bus.err_sticky);

    // 3: RED jumps straight to YELLOW
    drive(3'b001, 9); step(3'b100, 0);
    cmp("s3_order", 32'(bus.err_order), 32'd1);
    cmp("s3_phase", 32'(bus.phase), 32'd2);
    drive(3'b100, 2); step(3'b001, 0);
    cmp("s3_done", 32'(bus.cycle_done), 32'd1);
    cmp("s3_count", 32'(bus.cycle_count), 32'd3);
    $display("scenario 3: order error, count=%0d", bus.cycle_count);

    // 4: illegal code, then a timed GREEN
    for (int k = 0; k < 2; k++) begin
      step(3'b011, 0);
      cmp("s4_onehot", 32'(bus.err_onehot), 32'd1);
      cmp("s4_phase", 32'(bus.phase), 32'd3);
    end
    drive(3'b010, 10); step(3'b100, 0);
    cmp("s4_timing", 32'(bus.err_timing), 32'd0);
    cmp("s4_order", 32'(bus.err_order), 32'd0);
    $display("scenario 4: illegal code recovery");

    // 5: clear coincident with a timing error
    drive(3'b100, 2); step(3'b100, 1);
    cmp("s5_timing", 32'(bus.err_timing), 32'd1);
    cmp("s5_sticky", 32'(bus.err_sticky), 32'd1);
    cmp("s5_count", 32'(bus.cycle_count), 32'd0);
    step(3'b001, 0);
    $display("scenario 5: clear vs error");

    // 6: reset mid-GREEN
    drive(3'b001, 9); drive(3'b010, 5);
    do_reset();
    cmp("s6_phase", 32'(bus.phase), 32'd3);
    cmp("s6_count", 32'(bus.cycle_count), 32'd0);
    cmp("s6_sticky", 32'(bus.err_sticky), 32'd0);
    drive(3'b010, 2); step(3'b100, 0);
    cmp("s6_timing", 32'(bus.err_timing), 32'd0);
    $display("scenario 6: reset mid-phase");

    // Random segments of near-nominal length with occasional faults.
    rp = 2;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
        $display("seg %0d: reset", s);
      end else if (r < 8) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          step(bad_tab[$urandom_range(0, 4)], $urandom_range(0, 99) < 3);
        $display("seg %0d: illegal x%0d", s, n);
      end else begin
        rp = (r < 16) ? (rp + 2) % 3 : (rp + 1) % 3;
        len = exp_len[rp] + int'($urandom_range(0, 4)) - 2;
        if (len < 1) len = 1;
        for (int k = 0; k < len; k++)
          step(code_of(rp), $urandom_range(0, 99) < 3);
        $display("seg %0d: phase %0d x%0d", s, rp, len);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
